// File: rtl/pq_batch_sorter_if.sv
// Stream and priority-queue command bundle for pq_batch_sorter.
// master = the sorter itself, slave = producer/consumer/queue side.
interface pq_batch_sorter_if #(
  parameter int DATA_LENGTH = 32
);
  logic                   i_in_valid;
  logic                   o_in_ready;
  logic [DATA_LENGTH-1:0] i_in_data;
  logic                   i_in_last;

  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [DATA_LENGTH-1:0] o_out_data;
  logic                   o_out_last;

  logic                   o_pq_write;
  logic                   o_pq_valid;
  logic [DATA_LENGTH-1:0] o_pq_data;
  logic                   i_pq_full;
  logic                   i_pq_empty;
  logic                   i_pq_valid;
  logic [DATA_LENGTH-1:0] i_pq_data;

  logic                   o_busy;
  logic                   o_err;

  modport master (
    input  i_in_valid, i_in_data, i_in_last, i_out_ready,
           i_pq_full, i_pq_empty, i_pq_valid, i_pq_data,
    output o_in_ready, o_out_valid, o_out_data, o_out_last,
           o_pq_write, o_pq_valid, o_pq_data, o_busy, o_err
  );

  modport slave (
    output i_in_valid, i_in_data, i_in_last, i_out_ready,
           i_pq_full, i_pq_empty, i_pq_valid, i_pq_data,
    input  o_in_ready, o_out_valid, o_out_data, o_out_last,
           o_pq_write, o_pq_valid, o_pq_data, o_busy, o_err
  );
endinterface

// File: rtl/pq_batch_sorter.sv
// Loads a batch of words into an external priority queue, then drains it
// one pop at a time onto a valid/ready output stream tagged with last.
module pq_batch_sorter #(
  parameter int QUEUE_DEPTH = 10,
  parameter int DATA_LENGTH = 32,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1)
) (
  input logic                CLK,
  input logic                RSTn,
  pq_batch_sorter_if.master  bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_LENGTH-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   err_q, err_d;

  logic                   in_ready;
  logic                   pq_valid;
  logic                   pq_write;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    pq_valid    = 1'b0;
    pq_write    = 1'b0;

    unique case (state_q)
      LOAD: begin
        in_ready = !bus.i_pq_full && (count_q < DEPTH_C);
        pq_write = 1'b1;
        pq_valid = bus.i_in_valid && in_ready;
        if (pq_valid) begin
          count_d = count_q + ONE_C;
          if (count_q == '0) err_d = 1'b0;
          if (bus.i_in_last) begin
            state_d = ISSUE;
          end else if (count_d == DEPTH_C) begin
            // Batch truncated at capacity; drain what we have and flag it.
            state_d = ISSUE;
            err_d   = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (count_q == '0) begin
          state_d = LOAD;
        end else if (bus.i_pq_empty) begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = LOAD;
        end else begin
          pq_valid = 1'b1;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (bus.i_pq_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.i_pq_data;
          out_last_d  = (count_q == ONE_C);
          count_d     = count_q - ONE_C;
          state_d     = OUT;
        end else begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = LOAD;
        end
      end

      OUT: begin
        if (bus.i_out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (count_q == '0) ? LOAD : ISSUE;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering in simulation.
    if (!RSTn) begin
      state_q     <= LOAD;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_pq_valid  = pq_valid;
  assign bus.o_pq_write  = pq_write;
  assign bus.o_pq_data   = bus.i_in_data;
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_out_data  = out_data_q;
  assign bus.o_out_last  = out_last_q;
  assign bus.o_err       = err_q;
  assign bus.o_busy      = (state_q != LOAD) || (count_q != '0);

endmodule

// File: tb/tb_pq_batch_sorter.sv
// Directed bench for pq_batch_sorter with a behavioural min-first queue
// (stable for equal keys, 1-cycle pop latency, optional response drop).
module tb_pq_batch_sorter;

  typedef logic [31:0] arr_t [10];

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic drop = 1'b0;

  int passed = 0;
  int checks = 0;

  arr_t        qm;
  int          qn;
  logic        rv;
  logic [31:0] rd;

  logic [31:0] out_d [$];
  logic        out_l [$];
  int          cmd_cnt  = 0;
  int          push_cnt = 0;
  int          pop_cnt  = 0;

  pq_batch_sorter_if #(.DATA_LENGTH(32)) bus ();

  pq_batch_sorter #(.QUEUE_DEPTH(10), .DATA_LENGTH(32)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic arr_t q_ins(arr_t a, int n, logic [31:0] v);
    arr_t r;
    int   p;
    bit   found;
    r     = a;
    p     = n;
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!found && v < a[i]) begin
        p     = i;
        found = 1'b1;
      end
    end
    for (int i = n; i > p; i--) r[i] = a[i-1];
    r[p] = v;
    return r;
  endfunction

  function automatic arr_t q_pop(arr_t a);
    arr_t r;
    for (int i = 0; i < 9; i++) r[i] = a[i+1];
    r[9] = '0;
    return r;
  endfunction

  // Priority queue model sharing the reset.
  always @(posedge clk) begin
    if (!rstn) begin
      qn <= 0;
      rv <= 1'b0;
      rd <= '0;
    end else begin
      rv <= 1'b0;
      if (bus.o_pq_valid) begin
        if (bus.o_pq_write) begin
          if (qn < 10) begin
            qm <= q_ins(qm, qn, bus.o_pq_data);
            qn <= qn + 1;
          end
        end else if (qn > 0) begin
          rd <= qm[0];
          rv <= !drop;
          qm <= q_pop(qm);
          qn <= qn - 1;
        end
      end
    end
  end

  assign bus.i_pq_full  = (qn == 10);
  assign bus.i_pq_empty = (qn == 0);
  assign bus.i_pq_valid = rv;
  assign bus.i_pq_data  = rd;

  always @(negedge clk) begin
    if (bus.o_out_valid && bus.i_out_ready) begin
      out_d.push_back(bus.o_out_data);
      out_l.push_back(bus.o_out_last);
    end
    if (bus.o_pq_valid) begin
      cmd_cnt <= cmd_cnt + 1;
      if (bus.o_pq_write) push_cnt <= push_cnt + 1;
      else                pop_cnt  <= pop_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = d;
    bus.i_in_last  = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.o_in_ready) ok = 1'b1;
      tick();
    end
    bus.i_in_valid = 1'b0;
    bus.i_in_last  = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_outs(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (out_d.size() >= n) ok = 1'b1;
    end
    check("outputs_arrive", 32'(ok), 32'd1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.o_out_valid) ok = 1'b1;
      else tick();
    end
    check("out_valid_arrive", 32'(ok), 32'd1);
  endtask

  task automatic wait_err();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.o_err) ok = 1'b1;
      else tick();
    end
    check("err_arrive", 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] last_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < out_l.size() && i < 32; i++) m[i] = out_l[i];
    return m;
  endfunction

  initial begin
    logic [31:0] in1  [10] = '{12, 1, 2, 14, 12, 3, 0, 20, 25, 13};
    logic [31:0] exp1 [10] = '{0, 1, 2, 3, 12, 12, 13, 14, 20, 25};
    logic [31:0] in3  [10] = '{50, 40, 30, 20, 10, 60, 70, 80, 90, 5};
    logic [31:0] exp3 [10] = '{5, 10, 20, 30, 40, 50, 60, 70, 80, 90};
    logic [31:0] exp4 [4]  = '{4, 8, 17, 33};
    int p0;
    int q0;
    int c0;

    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
    bus.i_in_last   = 1'b0;
    bus.i_out_ready = 1'b1;

    // Reset held for two edges.
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
    check("rst_out_last",  32'(bus.o_out_last),  32'd0);
    check("rst_out_data",  bus.o_out_data,       32'd0);
    check("rst_err",       32'(bus.o_err),       32'd0);
    check("rst_pq_valid",  32'(bus.o_pq_valid),  32'd0);
    check("rst_busy",      32'(bus.o_busy),      32'd0);
    check("rst_in_ready",  32'(bus.o_in_ready),  32'd1);

    // Full batch of 10 with last on the final word.
    out_d.delete();
    out_l.delete();
    p0 = push_cnt;
    for (int i = 0; i < 10; i++) push_word(in1[i], i == 9);
    wait_outs(10);
    check("b1_pushes", 32'(push_cnt - p0), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("b1_data%0d", i), out_d[i], exp1[i]);
    check("b1_last_mask", last_mask(), 32'h200);
    check("b1_err", 32'(bus.o_err), 32'd0);

    // Single-word batch.
    out_d.delete();
    out_l.delete();
    p0 = push_cnt;
    q0 = pop_cnt;
    push_word(32'd7, 1'b1);
    wait_outs(1);
    check("b2_data",   out_d[0],             32'd7);
    check("b2_last",   32'(out_l[0]),        32'd1);
    check("b2_pushes", 32'(push_cnt - p0),   32'd1);
    check("b2_pops",   32'(pop_cnt - q0),    32'd1);
    check("b2_busy",   32'(bus.o_busy),      32'd0);

    // Eleven words without last: truncation at capacity.
    out_d.delete();
    out_l.delete();
    for (int i = 0; i < 10; i++) push_word(in3[i], 1'b0);
    check("b3_err_set",  32'(bus.o_err),      32'd1);
    check("b3_in_ready", 32'(bus.o_in_ready), 32'd0);
    wait_outs(10);
    for (int i = 0; i < 10; i++) check($sformatf("b3_data%0d", i), out_d[i], exp3[i]);
    check("b3_last_mask", last_mask(), 32'h200);
    check("b3_err_sticky", 32'(bus.o_err), 32'd1);
    push_word(32'd33, 1'b0);
    check("b3_err_clear", 32'(bus.o_err),  32'd0);
    check("b3_busy",      32'(bus.o_busy), 32'd1);

    // Continue that batch; stall the consumer on the second word.
    out_d.delete();
    out_l.delete();
    bus.i_out_ready = 1'b0;
    push_word(32'd4, 1'b0);
    push_word(32'd17, 1'b0);
    push_word(32'd8, 1'b1);
    wait_valid();
    check("b4_first", bus.o_out_data, 32'd4);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    wait_valid();
    c0 = cmd_cnt;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b4_hold_data%0d", i), bus.o_out_data, 32'd8);
      check($sformatf("b4_hold_last%0d", i), 32'(bus.o_out_last), 32'd0);
      tick();
    end
    check("b4_no_cmds", 32'(cmd_cnt - c0), 32'd0);
    bus.i_out_ready = 1'b1;
    wait_outs(4);
    for (int i = 0; i < 4; i++) check($sformatf("b4_data%0d", i), out_d[i], exp4[i]);
    check("b4_last_mask", last_mask(), 32'h8);
    check("b4_err", 32'(bus.o_err), 32'd0);

    // Queue drops its pop response.
    out_d.delete();
    out_l.delete();
    drop = 1'b1;
    push_word(32'd5, 1'b0);
    push_word(32'd6, 1'b0);
    push_word(32'd7, 1'b1);
    wait_err();
    drop = 1'b0;
    check("b5_err",      32'(bus.o_err),      32'd1);
    check("b5_busy",     32'(bus.o_busy),     32'd0);
    check("b5_in_ready", 32'(bus.o_in_ready), 32'd1);
    check("b5_no_outs",  32'(out_d.size()),   32'd0);

    // Reset while a word is held on the output; the queue still has 6 and 7.
    bus.i_out_ready = 1'b0;
    push_word(32'd40, 1'b0);
    check("b6_err_clear", 32'(bus.o_err), 32'd0);
    push_word(32'd30, 1'b1);
    wait_valid();
    check("b6_head", bus.o_out_data, 32'd6);
    rstn = 1'b0;
    tick();
    check("b6_out_valid", 32'(bus.o_out_valid), 32'd0);
    check("b6_out_data",  bus.o_out_data,       32'd0);
    check("b6_out_last",  32'(bus.o_out_last),  32'd0);
    check("b6_err",       32'(bus.o_err),       32'd0);
    check("b6_busy",      32'(bus.o_busy),      32'd0);
    check("b6_pq_valid",  32'(bus.o_pq_valid),  32'd0);
    rstn = 1'b1;
    bus.i_out_ready = 1'b1;
    tick();
    check("b6_in_ready",  32'(bus.o_in_ready),  32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
